// File: rtl/uart_pkg.sv
// Shared UART receiver constants: state encodings, oversampling timebase, vote ticks, majority vote.
// No logic and no latency of its own; no backpressure involved.
// Imported by the receiver top and its sub-modules.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int VOTE_T0    = 7;
  localparam int VOTE_T1    = 8;
  localparam int VOTE_T2    = 9;
  localparam int STOP_EXIT  = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the raw rx pin plus falling-edge detect on the synchronized level.
// Latency: 2 clocks to rx_q, fall valid in the same cycle rx_q first reads low.
// No backpressure: free-running, samples every clock.
module rx_sync_edge (
  input  logic clock_i,
  input  logic reset_i,
  input  logic rx,
  output logic rx_q,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  // Reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rx_q = sync2;
  assign fall = prev & ~sync2;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-of-3 vote per bit, good bytes on dout + rx_done_tick, separate frame_err/break_det pulses.
// Latency: result pulse one clock after the s_tick at vote tick 9 of the stop bit. Optional even parity: UART_RX_PARITY_EN.
// No backpressure: the loader must accept every rx_done_tick; a falling edge while busy is ignored.
module uart_rx_frame #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int NB_STATE   = 3
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                s_tick,
  input  logic                rx,
  output logic [NB_DATA-1:0]  dout,
  output logic                rx_done_tick,
  output logic                frame_err,
  output logic                break_det,
  output logic [NB_STATE-1:0] rx_state
);

  import uart_pkg::*;

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = $clog2(NB_DATA);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

  logic rx_q;
  logic fall;

  rx_sync_edge u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .rx      (rx),
    .rx_q    (rx_q),
    .fall    (fall)
  );

  rx_state_e          state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] sh_q, sh_d;
  logic [2:0]         smp_q, smp_d;
  logic               armed_q, armed_d;
  logic [NB_DATA-1:0] dout_q, dout_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;
  logic               bit_maj;
  logic               stop_maj;
  logic               good_frame;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
`endif

  assign bit_maj  = maj3(smp_q[0], smp_q[1], smp_q[2]);
  // The stop decision happens on the third vote tick itself, so the live sample stands in for smp[2].
  assign stop_maj = maj3(smp_q[0], smp_q[1], rx_q);

`ifdef UART_RX_PARITY_EN
  assign good_frame = stop_maj & ~(^{sh_q, par_q});
`else
  assign good_frame = stop_maj;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    armed_d = armed_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    if (s_tick && (state_q != ST_IDLE)) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
      if (s_q == S_W'(VOTE_T0)) smp_d[0] = rx_q;
      if (s_q == S_W'(VOTE_T1)) smp_d[1] = rx_q;
      if (s_q == S_W'(VOTE_T2)) smp_d[2] = rx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_q) armed_d = 1'b1;
        if (armed_q && fall) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick && (s_q == S_LAST)) begin
          if (bit_maj) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            n_d     = '0;
          end
        end
      end
      ST_DATA: begin
        if (s_tick && (s_q == S_LAST)) begin
          sh_d = {bit_maj, sh_q[NB_DATA-1:1]};
          if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick && (s_q == S_LAST)) begin
          par_d   = bit_maj;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick && (s_q == S_W'(STOP_EXIT))) begin
          state_d = ST_IDLE;
          s_d     = '0;
          if (good_frame) begin
            dout_d = sh_q;
            done_d = 1'b1;
          end else if (!stop_maj && (sh_q == '0)) begin
            brk_d   = 1'b1;
            armed_d = 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      smp_q   <= '0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      armed_q <= armed_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign rx_state     = NB_STATE'(state_q);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboarded bench for uart_rx_frame: frames are bit-banged against a local s_tick divider.
// Expected pulses are queued at send time and matched as the DUT pulses.
module tb_uart_rx_frame;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_BRK  = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       rx;
  logic [1:0] div = 2'd0;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       break_det;
  logic [2:0] rx_state;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  uart_rx_frame #(.NB_DATA(8), .OVERSAMPLE(16), .NB_STATE(3)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .rx_state     (rx_state)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) div <= div + 2'd1;
  assign s_tick = (div == 2'd3);

  // Advance to the next s_tick edge, checking every clock's pulses against the scoreboard.
  task automatic wait_tick();
    logic seen;
    exp_t e;
    seen = 1'b0;
    while (!seen) begin
      @(posedge clock_i);
      seen = s_tick;
      #1;
      if (rx_done_tick || frame_err || break_det) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse done=%0b ferr=%0b brk=%0b dout=%h", rx_done_tick, frame_err,
                   break_det, dout);
        end else begin
          e = exp_q.pop_front();
          if ({break_det, frame_err, rx_done_tick} !== e.kind ||
              (e.kind == K_DONE && dout !== e.data)) begin
            failures++;
            $display("FAIL pulse_match got kind=%b dout=%h expected kind=%b dout=%h",
                     {break_det, frame_err, rx_done_tick}, dout, e.kind, e.data);
          end
        end
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // One bit period; inv_tick selects the interval whose vote sample sees the inverted level.
  task automatic send_bit(input logic b, input int inv_tick);
    for (int k = 0; k < 16; k++) begin
      rx = (k == inv_tick) ? ~b : b;
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int inv_bit, input int inv_tick);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == inv_bit) ? inv_tick : -1);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, -1);
`endif
    send_bit(stop, -1);
    rx = 1'b1;
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name, input logic [7:0] want_dout);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_pulse pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (rx_state !== 3'd0) begin
      failures++;
      $display("FAIL %s_state got %0d expected 0", name, rx_state);
    end
    checks++;
    if (dout !== want_dout) begin
      failures++;
      $display("FAIL %s_dout got %h expected %h", name, dout, want_dout);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    rx      = 1'b1;
    repeat (5) @(posedge clock_i);
    #1;
    checks++;
    if ({rx_done_tick, frame_err, break_det} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got %b expected 000", {rx_done_tick, frame_err, break_det});
    end
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout got %h expected 00", dout);
    end
    checks++;
    if (rx_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got %0d expected 0", rx_state);
    end
    reset_i = 1'b0;
    wait_ticks(32);
  endtask

  task automatic test_good_frame();
    expect_pulse(K_DONE, 8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1);
    wait_ticks(16);
    check_drained("good_a5", 8'hA5);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(3);
    checks++;
    if (rx_state !== 3'd1) begin
      failures++;
      $display("FAIL glitch_in_start got %0d expected 1", rx_state);
    end
    wait_ticks(24);
    check_drained("glitch", 8'hA5);
  endtask

  task automatic test_frame_err();
    expect_pulse(K_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, -1, -1);
    wait_ticks(16);
    check_drained("frame_err", 8'hA5);
  endtask

  task automatic test_break();
    expect_pulse(K_BRK, 8'h00);
    rx = 1'b0;
    wait_ticks(180);
    checks++;
    if (rx_state !== 3'd0) begin
      failures++;
      $display("FAIL break_idle_low got %0d expected 0", rx_state);
    end
    wait_ticks(12);
    rx = 1'b1;
    wait_ticks(32);
    check_drained("break", 8'hA5);
    expect_pulse(K_DONE, 8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    wait_ticks(16);
    check_drained("after_break", 8'h11);
  endtask

  task automatic test_vote();
    expect_pulse(K_DONE, 8'h5A);
    send_frame(8'h5A, 1'b1, 3, 8);
    wait_ticks(16);
    check_drained("vote_5a", 8'h5A);
    expect_pulse(K_DONE, 8'hC3);
    send_frame(8'hC3, 1'b1, 0, 7);
    wait_ticks(16);
    check_drained("vote_c3", 8'hC3);
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, -1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, -1);
    wait_ticks(5);
    checks++;
    if (rx_state !== 3'd2) begin
      failures++;
      $display("FAIL mid_in_data got %0d expected 2", rx_state);
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if ({rx_done_tick, frame_err, break_det, rx_state, dout} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset_async got pulses=%b state=%0d dout=%h expected all 0",
               {rx_done_tick, frame_err, break_det}, rx_state, dout);
    end
    repeat (4) @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    wait_ticks(32);
    check_drained("mid_reset_idle", 8'h00);
    expect_pulse(K_DONE, 8'h42);
    send_frame(8'h42, 1'b1, -1, -1);
    wait_ticks(16);
    check_drained("after_reset", 8'h42);
  endtask

  task automatic test_back_to_back();
    expect_pulse(K_DONE, 8'h00);
    send_frame(8'h00, 1'b1, -1, -1);
    expect_pulse(K_DONE, 8'h81);
    send_frame(8'h81, 1'b1, -1, -1);
    expect_pulse(K_DONE, 8'hFF);
    send_frame(8'hFF, 1'b1, -1, -1);
    wait_ticks(16);
    check_drained("back_to_back", 8'hFF);
  endtask

  initial begin
    reset_i = 1'b1;
    rx      = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_break();
    test_vote();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
